// File: rtl/mem_responder.sv
// Wait-stated single-port 16-bit memory responder with range/alignment checking.
// Optional write protection below PROT_LIMIT is compiled in with `define MEM_PROTECT_EN.
module mem_responder #(
    parameter int unsigned DEPTH_LOG2  = 10,
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [15:0] PROT_LIMIT  = 16'h0100
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        ack,
    output logic        busy,
    output logic        err
`ifdef MEM_PROTECT_EN
    ,
    output logic        prot_viol
`endif
);

    localparam int unsigned Words   = 2 ** DEPTH_LOG2;
    localparam logic [3:0]  CntInit = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
`ifdef MEM_PROTECT_EN
    localparam logic        ProtEn  = 1'b1;
`else
    localparam logic        ProtEn  = 1'b0;
`endif

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q;
    logic [15:0] addr_q;
    logic [15:0] wdata_q;
    logic [15:0] rdata_q;

    logic [15:0] mem [Words];

    // The read happens on the edge entering RESP so rdata is valid alongside ack;
    // with zero wait states that edge is also the accepting edge, hence the mux.
    logic [15:0] acc_addr;
    logic        acc_we;
    logic        acc_valid;
    logic        load_rd;
    logic [15:0] rd_word;
    logic        valid_q;
    logic        prot_hit;
    logic        mem_we;

    assign acc_addr  = (state_q == StIdle) ? addr : addr_q;
    assign acc_we    = (state_q == StIdle) ? we : we_q;
    assign acc_valid = !acc_addr[0] && ({17'd0, acc_addr[15:1]} < Words);
    assign rd_word   = acc_valid ? mem[acc_addr[DEPTH_LOG2:1]] : 16'h0000;
    assign load_rd   = (state_d == StResp) && !acc_we;

    assign valid_q  = !addr_q[0] && ({17'd0, addr_q[15:1]} < Words);
    assign prot_hit = ProtEn && valid_q && we_q && (addr_q < PROT_LIMIT);
    assign mem_we   = (state_q == StResp) && we_q && valid_q && !prot_hit && !reset;

    // State register, request latch and read-data register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 16'h0000;
            wdata_q <= 16'h0000;
            rdata_q <= 16'h0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == StIdle && req) begin
                we_q    <= we;
                addr_q  <= addr;
                wdata_q <= wdata;
            end
            if (load_rd) begin
                rdata_q <= rd_word;
            end
        end
    end

    // Storage is deliberately not reset
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[addr_q[DEPTH_LOG2:1]] <= wdata_q;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    if (WAIT_STATES > 0) begin
                        state_d = StWait;
                        cnt_d   = CntInit;
                    end else begin
                        state_d = StResp;
                    end
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Outputs
    always_comb begin
        ack   = (state_q == StResp);
        busy  = (state_q != StIdle);
        err   = ack && !valid_q;
        rdata = rdata_q;
`ifdef MEM_PROTECT_EN
        prot_viol = ack && prot_hit;
`endif
    end

endmodule

// File: tb/tb_mem_responder.sv
// Randomized bench for mem_responder: three instances (1, 3 and 0 wait states)
// checked against a transaction-level memory model. Honours `define MEM_PROTECT_EN.
module tb_mem_responder;

    localparam int NDUT = 3;

    logic        clock = 1'b0;
    logic        reset [NDUT];
    logic        req   [NDUT];
    logic        we    [NDUT];
    logic [15:0] addr  [NDUT];
    logic [15:0] wdata [NDUT];
    logic [15:0] rdata [NDUT];
    logic        ack   [NDUT];
    logic        busy  [NDUT];
    logic        err   [NDUT];
`ifdef MEM_PROTECT_EN
    logic        prot_viol [NDUT];
`endif

    always #5 clock = ~clock;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        mem_responder #(
            .DEPTH_LOG2 (10),
            .WAIT_STATES((g == 0) ? 1 : ((g == 1) ? 3 : 0)),
            .PROT_LIMIT (16'h0100)
        ) u_dut (
            .clock    (clock),
            .reset    (reset[g]),
            .req      (req[g]),
            .we       (we[g]),
            .addr     (addr[g]),
            .wdata    (wdata[g]),
            .rdata    (rdata[g]),
            .ack      (ack[g]),
            .busy     (busy[g]),
            .err      (err[g])
`ifdef MEM_PROTECT_EN
            ,
            .prot_viol(prot_viol[g])
`endif
        );
    end

    int n_vec = 0;
    int n_err = 0;

    // Reference model: word contents keyed by dut*65536 + word index
    logic [15:0] mmem [int];
    logic [15:0] last_rd [NDUT];
    bit          last_known [NDUT];

    function automatic int ws_of(input int d);
        return (d == 0) ? 1 : ((d == 1) ? 3 : 0);
    endfunction

    function automatic bit addr_bad(input logic [15:0] a);
        return (a % 2 == 1) || ((int'(a) / 2) >= 1024);
    endfunction

    function automatic bit prot_expected(input logic w, input logic [15:0] a);
`ifdef MEM_PROTECT_EN
        return w && !addr_bad(a) && (a < 16'h0100);
`else
        return 1'b0;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // One complete transaction; returns only in the ack cycle (negedge sample)
    task automatic access(input int d, input logic w, input logic [15:0] a,
                          input logic [15:0] wd);
        int          cnt;
        bit          busy_ok;
        bit          quiet_ok;
        bit          e_err;
        bit          e_prot;
        bit          rd_known;
        logic [15:0] e_rd;
        int          key;
        key      = d * 65536 + int'(a) / 2;
        e_err    = addr_bad(a);
        e_prot   = prot_expected(w, a);
        rd_known = 1'b1;
        if (!w) begin
            if (e_err) e_rd = 16'h0000;
            else if (mmem.exists(key)) e_rd = mmem[key];
            else begin
                e_rd     = 16'h0000;
                rd_known = 1'b0;
            end
        end else begin
            e_rd     = last_rd[d];
            rd_known = last_known[d];
        end
        @(posedge clock);
        #1;
        req[d] = 1'b1; we[d] = w; addr[d] = a; wdata[d] = wd;
        @(posedge clock);
        #1;
        req[d] = 1'b0; addr[d] = 16'($urandom); wdata[d] = 16'($urandom);
        cnt      = 0;
        busy_ok  = 1'b1;
        quiet_ok = 1'b1;
        while (cnt < 40) begin
            @(negedge clock);
            cnt++;
            if (!busy[d]) busy_ok = 1'b0;
            if (ack[d]) break;
            if (err[d]) quiet_ok = 1'b0;
        end
        check($sformatf("latency%0d", d), cnt, ws_of(d) + 1);
        check($sformatf("busy%0d", d), busy_ok, 1);
        check($sformatf("quiet%0d", d), quiet_ok, 1);
        check($sformatf("err%0d", d), err[d], e_err);
`ifdef MEM_PROTECT_EN
        check($sformatf("prot%0d", d), prot_viol[d], e_prot);
`endif
        if (rd_known) check($sformatf("rdata%0d", d), rdata[d], e_rd);
        if (w) begin
            if (!e_err && !e_prot) mmem[key] = wd;
        end else begin
            last_rd[d]    = e_rd;
            last_known[d] = rd_known;
        end
    endtask

    initial begin
        int          n_ack;
        int          n_busy;
        int          ack_at;
        logic [15:0] a;
        logic        w;
        int          r;

        for (int d = 0; d < NDUT; d++) begin
            reset[d] = 1'b1; req[d] = 1'b0; we[d] = 1'b0;
            addr[d] = 16'h0000; wdata[d] = 16'h0000;
            last_rd[d] = 16'h0000; last_known[d] = 1'b1;
        end
        repeat (2) @(posedge clock);
        #1;
        for (int d = 0; d < NDUT; d++) reset[d] = 1'b0;
        @(negedge clock);
        for (int d = 0; d < NDUT; d++) begin
            check("rst_rdata", rdata[d], 16'h0000);
            check("rst_ack", ack[d], 0);
            check("rst_busy", busy[d], 0);
            check("rst_err", err[d], 0);
`ifdef MEM_PROTECT_EN
            check("rst_prot", prot_viol[d], 0);
`endif
        end

        // Basic write/read and error responses
        access(0, 1'b1, 16'h0210, 16'h1234);
        access(0, 1'b0, 16'h0210, 16'h0000);
        check("rd_1234", rdata[0], 16'h1234);
        access(0, 1'b0, 16'h0011, 16'h0000);
        access(0, 1'b0, 16'h0800, 16'h0000);
        access(0, 1'b1, 16'h0004, 16'hBEEF);
        access(0, 1'b0, 16'h0004, 16'h0000);
`ifdef MEM_PROTECT_EN
        check("prot_readback", rdata[0] == 16'hBEEF, 0);
`else
        check("prot_readback", rdata[0], 16'hBEEF);
`endif

        // Second request one cycle after the first is ignored (3 wait states)
        access(1, 1'b1, 16'h0220, 16'h7777);
        @(posedge clock);
        #1;
        req[1] = 1'b1; we[1] = 1'b0; addr[1] = 16'h0220;
        @(posedge clock);
        #1;
        we[1] = 1'b1; wdata[1] = 16'h9999;
        n_ack = 0; n_busy = 0; ack_at = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clock);
            if (busy[1]) n_busy++;
            if (ack[1]) begin
                n_ack++;
                ack_at = i;
                check("ign_rdata", rdata[1], 16'h7777);
            end
            if (i == 1) begin
                @(posedge clock);
                #1;
                req[1] = 1'b0;
            end
        end
        check("ign_nack", n_ack, 1);
        check("ign_ackat", ack_at, 4);
        check("ign_busy", n_busy, 4);
        last_rd[1] = 16'h7777;
        access(1, 1'b0, 16'h0220, 16'h0000);

        // Reset during WAIT aborts a pending write
        access(1, 1'b1, 16'h0300, 16'hAAAA);
        access(1, 1'b0, 16'h0300, 16'h0000);
        @(posedge clock);
        #1;
        req[1] = 1'b1; we[1] = 1'b1; addr[1] = 16'h0300; wdata[1] = 16'h5555;
        @(posedge clock);
        #1;
        req[1] = 1'b0; reset[1] = 1'b1;
        @(posedge clock);
        #1;
        reset[1] = 1'b0;
        @(negedge clock);
        check("abort_rdata", rdata[1], 16'h0000);
        check("abort_busy", busy[1], 0);
        n_ack = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            if (ack[1]) n_ack++;
        end
        check("abort_nack", n_ack, 0);
        last_rd[1] = 16'h0000;
        access(1, 1'b0, 16'h0300, 16'h0000);
        check("abort_keep", rdata[1], 16'hAAAA);

        // Zero wait states: back-to-back writes then reads
        for (int i = 0; i < 8; i++) access(2, 1'b1, 16'(16'h0400 + 2 * i), 16'(16'hC000 + i));
        for (int i = 0; i < 8; i++) access(2, 1'b0, 16'(16'h0400 + 2 * i), 16'h0000);

        // Randomized traffic on every instance
        for (int d = 0; d < NDUT; d++) begin
            for (int n = 0; n < 40; n++) begin
                r = int'($urandom_range(0, 9));
                w = 1'($urandom_range(0, 1));
                if (r == 0) a = 16'($urandom) | 16'h0001;
                else if (r == 1) a = 16'(16'h0800 + 2 * $urandom_range(0, 16'h7BFF));
                else if (r == 2) a = 16'(2 * $urandom_range(0, 16'h7F));
                else a = 16'(16'h0200 + 2 * $urandom_range(0, 15));
                if (!w && !addr_bad(a) && !mmem.exists(d * 65536 + int'(a) / 2)) w = 1'b1;
                access(d, w, a, 16'($urandom));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
